// File: rtl/dat_mem_resp_if.sv
// Data-memory request/response bundle between the memory-access stage (master)
// and the data memory responder (slave).
interface dat_mem_resp_if;
  logic        memReq;
  logic        memWr;
  logic [31:0] memAddr;
  logic [31:0] memWrDat;
  logic [3:0]  memBe;
  logic        memAck;
  logic [31:0] memRdDat;
  logic        memErr;

  modport master (output memReq, memWr, memAddr, memWrDat, memBe,
                  input  memAck, memRdDat, memErr);
  modport slave  (input  memReq, memWr, memAddr, memWrDat, memBe,
                  output memAck, memRdDat, memErr);
endinterface

// File: rtl/dat_mem_resp.sv
// Word-organised data memory answering one load/store at a time over req/ack,
// with WAIT_CYC wait states, byte-enabled stores and misalign/range errors.
module dat_mem_resp #(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input logic          clk,
  input logic          rstN,
  dat_mem_resp_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam bit       NO_WAIT  = (WAIT_CYC == 0);
  localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYC - 1);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                wr_q;
  logic [31:0]         addr_q, wdat_q;
  logic [3:0]          be_q;
  logic                ack_q, err_q;
  logic [31:0]         rd_q;
  logic [31:0]         mem [2**ADDR_W];

  logic                go_resp, cur_wr, cur_err;
  logic [31:0]         cur_addr, cur_wdat;
  logic [3:0]          cur_be;
  logic [ADDR_W-1:0]   cur_idx;

  // With no wait states the request is answered straight from the bus,
  // otherwise from the copy captured at acceptance.
  always_comb begin
    go_resp  = 1'b0;
    cur_wr   = wr_q;
    cur_addr = addr_q;
    cur_wdat = wdat_q;
    cur_be   = be_q;
    if (state_q == IDLE) begin
      go_resp  = bus.memReq && NO_WAIT;
      cur_wr   = bus.memWr;
      cur_addr = bus.memAddr;
      cur_wdat = bus.memWrDat;
      cur_be   = bus.memBe;
    end else if (state_q == WAIT) begin
      go_resp  = (cnt_q == 4'd0);
    end
    cur_idx = cur_addr[ADDR_W+1:2];
    cur_err = (cur_addr[1:0] != 2'b00) || (cur_addr[31:ADDR_W+2] != '0);
  end

  // Array has no reset; a reset edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (rstN && go_resp && cur_wr && !cur_err) begin
      for (int b = 0; b < 4; b++)
        if (cur_be[b]) mem[cur_idx][8*b +: 8] <= cur_wdat[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdat_q  <= 32'd0;
      be_q    <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 32'd0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rd_q  <= 32'd0;
      if (go_resp) begin
        ack_q <= 1'b1;
        err_q <= cur_err;
        rd_q  <= (cur_wr || cur_err) ? 32'd0 : mem[cur_idx];
      end
      case (state_q)
        IDLE: if (bus.memReq) begin
          wr_q    <= bus.memWr;
          addr_q  <= bus.memAddr;
          wdat_q  <= bus.memWrDat;
          be_q    <= bus.memBe;
          cnt_q   <= CNT_INIT;
          state_q <= NO_WAIT ? RESP : WAIT;
        end
        WAIT: if (cnt_q == 4'd0) state_q <= RESP;
              else               cnt_q   <= cnt_q - 4'd1;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.memAck   = ack_q;
  assign bus.memErr   = err_q;
  assign bus.memRdDat = rd_q;
endmodule

// File: tb/tb_dat_mem_resp.sv
// Randomised and directed bench for dat_mem_resp against a word-array model
// with a time-stamped queue of expected responses.
module tb_dat_mem_resp;
  localparam int AW  = 8;
  localparam int W   = 2;
  localparam int PER = 10;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #(PER/2) clk = ~clk;

  dat_mem_resp_if bus ();
  dat_mem_resp_if bus0 ();

  dat_mem_resp #(.ADDR_W(AW), .WAIT_CYC(W)) dut  (.clk(clk), .rstN(rstN), .bus(bus));
  dat_mem_resp #(.ADDR_W(AW), .WAIT_CYC(0)) dut0 (.clk(clk), .rstN(rstN), .bus(bus0));

  typedef struct {time t; logic err; logic [31:0] rd;} exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;
  logic [31:0] mm [2**AW];
  exp_t        expq [$];

  logic        a, e;
  logic [31:0] r;
  time         t1, t2;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endfunction

  // Spec rules applied to the model array; returns the response due at time t.
  function automatic exp_t model(bit wr, logic [31:0] ad, logic [31:0] d, logic [3:0] be, time t);
    exp_t x;
    int   idx;
    x.t   = t;
    x.err = (ad[1:0] != 2'b00) || ((ad >> (AW + 2)) != 32'd0);
    x.rd  = 32'd0;
    idx   = int'(ad[AW+1:2]);
    if (!x.err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mm[idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        x.rd = mm[idx];
      end
    end
    return x;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (expq.size() > 0 && expq[0].t < $time) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed ack, expected at %0t", expq[0].t);
        void'(expq.pop_front());
      end
      if (expq.size() > 0 && expq[0].t == $time) begin
        chk("ack",  32'(bus.memAck), 32'd1);
        chk("err",  32'(bus.memErr), 32'(expq[0].err));
        chk("rdat", bus.memRdDat,    expq[0].rd);
        void'(expq.pop_front());
      end else begin
        chk("idle ack",  32'(bus.memAck), 32'd0);
        chk("idle err",  32'(bus.memErr), 32'd0);
        chk("idle rdat", bus.memRdDat,    32'd0);
      end
    end
  end

  // Accept at the next rising edge; leaves the caller at the ack sample point.
  task automatic issue(input bit wr, input logic [31:0] ad, input logic [31:0] d,
                       input logic [3:0] be, input bit keep,
                       output logic ack, output logic err, output logic [31:0] rd,
                       output time tack);
    @(negedge clk);
    bus.memReq = 1'b1; bus.memWr = wr; bus.memAddr = ad; bus.memWrDat = d; bus.memBe = be;
    @(posedge clk);
    expq.push_back(model(wr, ad, d, be, $time + W*PER + PER/2));
    @(negedge clk);
    bus.memReq   = keep;
    bus.memWr    = 1'($urandom);
    bus.memAddr  = $urandom;
    bus.memWrDat = $urandom;
    bus.memBe    = 4'($urandom);
    repeat (W) @(negedge clk);
    ack  = bus.memAck;
    err  = bus.memErr;
    rd   = bus.memRdDat;
    tack = $time;
  endtask

  initial begin
    bus.memReq = 1'b0;  bus.memWr = 1'b0;  bus.memAddr = '0;  bus.memWrDat = '0;  bus.memBe = '0;
    bus0.memReq = 1'b0; bus0.memWr = 1'b0; bus0.memAddr = '0; bus0.memWrDat = '0; bus0.memBe = '0;
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ack",  32'(bus.memAck), 32'd0);
    chk("reset err",  32'(bus.memErr), 32'd0);
    chk("reset rdat", bus.memRdDat,    32'd0);
    chk_en = 1'b1;
    rstN   = 1'b1;

    for (int i = 0; i < 2**AW; i++)
      issue(1'b1, 32'(i) << 2, 32'hA500_0000 | 32'(i), 4'hF, 1'b0, a, e, r, t1);

    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, a, e, r, t1);
    chk("st latency ack", 32'(a), 32'd1);
    chk("st err",         32'(e), 32'd0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, a, e, r, t1);
    chk("ld latency ack", 32'(a), 32'd1);
    chk("ld 0x10",        r,      32'hDEAD_BEEF);
    issue(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 1'b0, a, e, r, t1);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, a, e, r, t1);
    chk("ld be0001", r, 32'hDEAD_BEAA);

    issue(1'b0, 32'h12, 32'h0, 4'h0, 1'b0, a, e, r, t1);
    chk("misalign ack",  32'(a), 32'd1);
    chk("misalign err",  32'(e), 32'd1);
    chk("misalign rdat", r,      32'd0);
    issue(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 1'b0, a, e, r, t1);
    chk("range err", 32'(e), 32'd1);
    issue(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, a, e, r, t1);
    chk("word0 intact", r, 32'hA500_0000);

    issue(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a, e, r, t1);
    chk("b2b ld0", r, 32'hA500_0000);
    issue(1'b0, 32'h4, 32'h0, 4'h0, 1'b0, a, e, r, t2);
    chk("b2b ld4", r, 32'hA500_0001);
    chk("b2b spacing", 32'(t2 - t1), 32'((W + 2) * PER));

    // Store aborted by reset while waiting: no ack, memory untouched.
    @(negedge clk);
    bus.memReq = 1'b1; bus.memWr = 1'b1; bus.memAddr = 32'h20;
    bus.memWrDat = 32'h1234_5678; bus.memBe = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus.memReq = 1'b0;
    rstN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post-rst ack",  32'(bus.memAck), 32'd0);
    chk("post-rst err",  32'(bus.memErr), 32'd0);
    chk("post-rst rdat", bus.memRdDat,    32'd0);
    rstN = 1'b1;
    issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, a, e, r, t1);
    chk("ld after rst", r, 32'hA500_0008);

    issue(1'b0, 32'h24, 32'h0, 4'h0, 1'b0, a, e, r, t1);
    chk("addr change ignored", r, 32'hA500_0009);

    @(negedge clk);
    bus0.memReq = 1'b1; bus0.memWr = 1'b1; bus0.memAddr = 32'h8;
    bus0.memWrDat = 32'hCAFE_F00D; bus0.memBe = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk("w0 st ack", 32'(bus0.memAck), 32'd1);
    chk("w0 st err", 32'(bus0.memErr), 32'd0);
    bus0.memReq = 1'b0;
    @(negedge clk);
    chk("w0 ack single", 32'(bus0.memAck), 32'd0);
    bus0.memReq = 1'b1; bus0.memWr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("w0 ld ack",  32'(bus0.memAck), 32'd1);
    chk("w0 ld rdat", bus0.memRdDat,    32'hCAFE_F00D);
    bus0.memReq = 1'b0;
    @(negedge clk);
    chk("w0 ld ack drop", 32'(bus0.memAck), 32'd0);

    for (int k = 0; k < 400; k++) begin
      logic [31:0] ad;
      int          sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       ad = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      else if (sel == 7) ad = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      else               ad = $urandom | 32'h400;
      issue(1'($urandom), ad, $urandom, 4'($urandom),
            (k < 399) ? 1'($urandom) : 1'b0, a, e, r, t1);
    end

    repeat (5) @(negedge clk);
    chk("pending acks", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
